// File: rtl/wb_pkg.sv
// Shared widths, state encoding and pipeline-entry layout for the writeback stage.
package wb_pkg;
  localparam int DATA_W = 64;
  localparam int REG_W  = 4;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_REG,
    WB_STORE,
    WB_HALTED
  } wb_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_result_special;
    logic [REG_W-1:0]  dest_reg;
    logic              dest_reg_valid;
    logic [REG_W-1:0]  dest_reg_special;
    logic              dest_reg_special_valid;
    logic              is_mem;
    logic [DATA_W-1:0] mem_addr;
    logic              kill;
    logic [DATA_W-1:0] rip;
  } wb_entry_t;

  // Port 1 yields to port 2 when both target the same register.
  function automatic logic port1_enabled(wb_entry_t e);
    return e.dest_reg_valid &&
           !(e.dest_reg_special_valid && (e.dest_reg == e.dest_reg_special));
  endfunction
endpackage

// File: rtl/wb_pipe_reg.sv
// Single-entry pipeline register holding the instruction being retired.
module wb_pipe_reg
  import wb_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      load,
  input  wb_entry_t entry_in,
  output wb_entry_t entry_q
);
  wb_entry_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (load) entry_d = entry_in;
  end

  always_ff @(posedge clk) begin
    if (reset) entry_q <= '0;
    else       entry_q <= entry_d;
  end
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires one instruction via register writes, a store
// handshake, or a halting kill. All outputs are registered.
//   state     | meaning
//   WB_IDLE   | empty, ready to accept
//   WB_REG    | register write cycle, ready to accept
//   WB_STORE  | store request outstanding, execute stalled
//   WB_HALTED | killed, left only by reset
module writeback_stage #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int REG_W  = wb_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exValidIn,
  output logic              wbReadyOut,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] aluResultSpecialIn,
  input  logic [REG_W-1:0]  destRegIn,
  input  logic              destRegValidIn,
  input  logic [REG_W-1:0]  destRegSpecialIn,
  input  logic              destRegSpecialValidIn,
  input  logic              isMemoryAccessDestIn,
  input  logic [DATA_W-1:0] memoryAddressDestIn,
  input  logic              killIn,
  input  logic [DATA_W-1:0] currentRipIn,
  output logic              regWrEnOut,
  output logic [REG_W-1:0]  regWrAddrOut,
  output logic [DATA_W-1:0] regWrDataOut,
  output logic              regWr2EnOut,
  output logic [REG_W-1:0]  regWr2AddrOut,
  output logic [DATA_W-1:0] regWr2DataOut,
  output logic              memStoreReqOut,
  output logic [DATA_W-1:0] memStoreAddrOut,
  output logic [DATA_W-1:0] memStoreDataOut,
  input  logic              memStoreAckIn,
  output logic              retireValidOut,
  output logic [DATA_W-1:0] retireRipOut,
  output logic [63:0]       retireCountOut,
  output logic              haltedOut
);
  import wb_pkg::*;

  wb_state_t         state_q, state_d;
  wb_entry_t         entry_in, entry_q, entry_nxt;
  logic              accept;
  logic              wb_ready_q, wb_ready_d;
  logic              reg_wr_en_q, reg_wr_en_d;
  logic [REG_W-1:0]  reg_wr_addr_q, reg_wr_addr_d;
  logic [DATA_W-1:0] reg_wr_data_q, reg_wr_data_d;
  logic              reg_wr2_en_q, reg_wr2_en_d;
  logic [REG_W-1:0]  reg_wr2_addr_q, reg_wr2_addr_d;
  logic [DATA_W-1:0] reg_wr2_data_q, reg_wr2_data_d;
  logic              store_req_q, store_req_d;
  logic [DATA_W-1:0] store_addr_q, store_addr_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic              retire_valid_q, retire_valid_d;
  logic [DATA_W-1:0] retire_rip_q, retire_rip_d;
  logic [63:0]       retire_count_q, retire_count_d;
  logic              halted_q, halted_d;

  assign entry_in = '{
    alu_result:             aluResultIn,
    alu_result_special:     aluResultSpecialIn,
    dest_reg:               destRegIn,
    dest_reg_valid:         destRegValidIn,
    dest_reg_special:       destRegSpecialIn,
    dest_reg_special_valid: destRegSpecialValidIn,
    is_mem:                 isMemoryAccessDestIn,
    mem_addr:               memoryAddressDestIn,
    kill:                   killIn,
    rip:                    currentRipIn
  };

  wb_pipe_reg u_pipe_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .entry_in (entry_in),
    .entry_q  (entry_q)
  );

  // Outputs are computed from the entry the pipe register holds after this edge.
  always_comb begin
    accept    = exValidIn && wb_ready_q;
    entry_nxt = accept ? entry_in : entry_q;
    state_d   = state_q;
    case (state_q)
      WB_IDLE, WB_REG: begin
        if (!accept)              state_d = WB_IDLE;
        else if (entry_nxt.kill)  state_d = WB_HALTED;
        else if (entry_nxt.is_mem) state_d = WB_STORE;
        else                      state_d = WB_REG;
      end
      WB_STORE:  if (memStoreAckIn) state_d = WB_IDLE;
      WB_HALTED: state_d = WB_HALTED;
      default:   state_d = WB_IDLE;
    endcase

    wb_ready_d     = (state_d == WB_IDLE) || (state_d == WB_REG);
    reg_wr_en_d    = (state_d == WB_REG) && port1_enabled(entry_nxt);
    reg_wr_addr_d  = entry_nxt.dest_reg;
    reg_wr_data_d  = entry_nxt.alu_result;
    reg_wr2_en_d   = (state_d == WB_REG) && entry_nxt.dest_reg_special_valid;
    reg_wr2_addr_d = entry_nxt.dest_reg_special;
    reg_wr2_data_d = entry_nxt.alu_result_special;
    store_req_d    = (state_d == WB_STORE);
    store_addr_d   = entry_nxt.mem_addr;
    store_data_d   = entry_nxt.alu_result;
    retire_valid_d = (state_d == WB_REG) ||
                     ((state_q == WB_STORE) && memStoreAckIn) ||
                     ((state_d == WB_HALTED) && (state_q != WB_HALTED));
    retire_rip_d   = entry_nxt.rip;
    retire_count_d = retire_count_q + 64'(retire_valid_q);
    halted_d       = (state_d == WB_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WB_IDLE;
      wb_ready_q     <= 1'b1;
      reg_wr_en_q    <= 1'b0;
      reg_wr_addr_q  <= '0;
      reg_wr_data_q  <= '0;
      reg_wr2_en_q   <= 1'b0;
      reg_wr2_addr_q <= '0;
      reg_wr2_data_q <= '0;
      store_req_q    <= 1'b0;
      store_addr_q   <= '0;
      store_data_q   <= '0;
      retire_valid_q <= 1'b0;
      retire_rip_q   <= '0;
      retire_count_q <= '0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wb_ready_q     <= wb_ready_d;
      reg_wr_en_q    <= reg_wr_en_d;
      reg_wr_addr_q  <= reg_wr_addr_d;
      reg_wr_data_q  <= reg_wr_data_d;
      reg_wr2_en_q   <= reg_wr2_en_d;
      reg_wr2_addr_q <= reg_wr2_addr_d;
      reg_wr2_data_q <= reg_wr2_data_d;
      store_req_q    <= store_req_d;
      store_addr_q   <= store_addr_d;
      store_data_q   <= store_data_d;
      retire_valid_q <= retire_valid_d;
      retire_rip_q   <= retire_rip_d;
      retire_count_q <= retire_count_d;
      halted_q       <= halted_d;
    end
  end

  assign wbReadyOut      = wb_ready_q;
  assign regWrEnOut      = reg_wr_en_q;
  assign regWrAddrOut    = reg_wr_addr_q;
  assign regWrDataOut    = reg_wr_data_q;
  assign regWr2EnOut     = reg_wr2_en_q;
  assign regWr2AddrOut   = reg_wr2_addr_q;
  assign regWr2DataOut   = reg_wr2_data_q;
  assign memStoreReqOut  = store_req_q;
  assign memStoreAddrOut = store_addr_q;
  assign memStoreDataOut = store_data_q;
  assign retireValidOut  = retire_valid_q;
  assign retireRipOut    = retire_rip_q;
  assign retireCountOut  = retire_count_q;
  assign haltedOut       = halted_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized instruction mix
// checked against a transaction-level model of retirement.
module tb_writeback_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        exValidIn, wbReadyOut;
  logic [63:0] aluResultIn, aluResultSpecialIn, memoryAddressDestIn, currentRipIn;
  logic [3:0]  destRegIn, destRegSpecialIn;
  logic        destRegValidIn, destRegSpecialValidIn, isMemoryAccessDestIn, killIn;
  logic        regWrEnOut, regWr2EnOut, memStoreReqOut, memStoreAckIn;
  logic [3:0]  regWrAddrOut, regWr2AddrOut;
  logic [63:0] regWrDataOut, regWr2DataOut, memStoreAddrOut, memStoreDataOut;
  logic        retireValidOut, haltedOut;
  logic [63:0] retireRipOut, retireCountOut;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] retired;

  typedef struct packed {
    logic [63:0] res, res2, addr, rip;
    logic [3:0]  d1, d2;
    logic        v1, v2, mem, kill;
  } instr_t;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .reset(reset), .exValidIn(exValidIn), .wbReadyOut(wbReadyOut),
    .aluResultIn(aluResultIn), .aluResultSpecialIn(aluResultSpecialIn),
    .destRegIn(destRegIn), .destRegValidIn(destRegValidIn),
    .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
    .isMemoryAccessDestIn(isMemoryAccessDestIn), .memoryAddressDestIn(memoryAddressDestIn),
    .killIn(killIn), .currentRipIn(currentRipIn),
    .regWrEnOut(regWrEnOut), .regWrAddrOut(regWrAddrOut), .regWrDataOut(regWrDataOut),
    .regWr2EnOut(regWr2EnOut), .regWr2AddrOut(regWr2AddrOut), .regWr2DataOut(regWr2DataOut),
    .memStoreReqOut(memStoreReqOut), .memStoreAddrOut(memStoreAddrOut),
    .memStoreDataOut(memStoreDataOut), .memStoreAckIn(memStoreAckIn),
    .retireValidOut(retireValidOut), .retireRipOut(retireRipOut),
    .retireCountOut(retireCountOut), .haltedOut(haltedOut)
  );

  // Port 1 is dropped when port 2 targets the same register.
  function automatic logic p1_fires(input instr_t t);
    return t.v1 && !(t.v2 && (t.d1 == t.d2));
  endfunction

  function automatic instr_t rand_instr(input logic mem);
    instr_t t;
    t.res  = {$urandom, $urandom};
    t.res2 = {$urandom, $urandom};
    t.addr = {$urandom, $urandom};
    t.rip  = {$urandom, $urandom};
    t.d1   = 4'($urandom);
    t.d2   = ($urandom_range(0, 2) == 0) ? t.d1 : 4'($urandom);
    t.v1   = 1'($urandom);
    t.v2   = 1'($urandom);
    t.mem  = mem;
    t.kill = 1'b0;
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input instr_t t, input logic valid);
    exValidIn             = valid;
    aluResultIn           = t.res;
    aluResultSpecialIn    = t.res2;
    destRegIn             = t.d1;
    destRegValidIn        = t.v1;
    destRegSpecialIn      = t.d2;
    destRegSpecialValidIn = t.v2;
    isMemoryAccessDestIn  = t.mem;
    memoryAddressDestIn   = t.addr;
    killIn                = t.kill;
    currentRipIn          = t.rip;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    memStoreAckIn = 1'b0;
    drive('0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    retired = '0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({wbReadyOut, retireValidOut, memStoreReqOut, haltedOut, regWrEnOut, regWr2EnOut} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected %b",
               {wbReadyOut, retireValidOut, memStoreReqOut, haltedOut, regWrEnOut, regWr2EnOut}, 6'b100000);
    end
    n_tests++;
    if (retireCountOut !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", retireCountOut);
    end
    n_tests++;
    if ({regWrAddrOut, regWrDataOut, regWr2AddrOut, regWr2DataOut, memStoreAddrOut, memStoreDataOut, retireRipOut} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected all zero",
               {regWrAddrOut, regWrDataOut, regWr2AddrOut, regWr2DataOut, memStoreAddrOut, memStoreDataOut, retireRipOut});
    end
    tick();
    tick();
    n_tests++;
    if ({wbReadyOut, retireValidOut, regWrEnOut} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_hold: got %b expected 100", {wbReadyOut, retireValidOut, regWrEnOut});
    end
  endtask

  task automatic test_add;
    instr_t t;
    t = '0;
    t.res = 64'h5; t.d1 = 4'd0; t.v1 = 1'b1; t.rip = 64'h4000_0010;
    drive(t, 1'b1);
    tick();
    drive('0, 1'b0);
    n_tests++;
    if ({regWrEnOut, regWrAddrOut, regWrDataOut, regWr2EnOut} !== {1'b1, 4'd0, 64'h5, 1'b0}) begin
      n_fail++;
      $display("FAIL add_write: got en=%b addr=%h data=%h en2=%b expected en=1 addr=0 data=5 en2=0",
               regWrEnOut, regWrAddrOut, regWrDataOut, regWr2EnOut);
    end
    n_tests++;
    if ({retireValidOut, retireRipOut} !== {1'b1, t.rip}) begin
      n_fail++;
      $display("FAIL add_retire: got v=%b rip=%h expected v=1 rip=%h", retireValidOut, retireRipOut, t.rip);
    end
    retired++;
    tick();
    n_tests++;
    if ({regWrEnOut, retireValidOut, retireCountOut} !== {2'b00, retired}) begin
      n_fail++;
      $display("FAIL add_after: got en=%b v=%b count=%0d expected en=0 v=0 count=%0d",
               regWrEnOut, retireValidOut, retireCountOut, retired);
    end
  endtask

  task automatic test_mul(input logic [3:0] a1, input logic [3:0] a2);
    instr_t t;
    t = '0;
    t.res = 64'h1; t.res2 = 64'h2; t.d1 = a1; t.d2 = a2; t.v1 = 1'b1; t.v2 = 1'b1;
    t.rip = {$urandom, $urandom};
    drive(t, 1'b1);
    tick();
    drive('0, 1'b0);
    n_tests++;
    if (regWrEnOut !== p1_fires(t) || (regWrEnOut && {regWrAddrOut, regWrDataOut} !== {t.d1, t.res})) begin
      n_fail++;
      $display("FAIL mul_port1: got en=%b addr=%h data=%h expected en=%b addr=%h data=%h",
               regWrEnOut, regWrAddrOut, regWrDataOut, p1_fires(t), t.d1, t.res);
    end
    n_tests++;
    if ({regWr2EnOut, regWr2AddrOut, regWr2DataOut} !== {1'b1, t.d2, t.res2}) begin
      n_fail++;
      $display("FAIL mul_port2: got en=%b addr=%h data=%h expected en=1 addr=%h data=%h",
               regWr2EnOut, regWr2AddrOut, regWr2DataOut, t.d2, t.res2);
    end
    retired++;
    tick();
  endtask

  task automatic test_store(input logic [63:0] addr, input logic [63:0] data, input int delay);
    instr_t t;
    t = '0;
    t.mem = 1'b1; t.addr = addr; t.res = data; t.v1 = 1'b1; t.rip = {$urandom, $urandom};
    drive(t, 1'b1);
    tick();
    for (int i = 0; i <= delay; i++) begin
      n_tests++;
      if ({wbReadyOut, retireValidOut, memStoreReqOut, regWrEnOut, regWr2EnOut} !== 5'b00100 ||
          {memStoreAddrOut, memStoreDataOut} !== {addr, data}) begin
        n_fail++;
        $display("FAIL store_wait[%0d]: got flags=%b addr=%h data=%h expected flags=00100 addr=%h data=%h", i,
                 {wbReadyOut, retireValidOut, memStoreReqOut, regWrEnOut, regWr2EnOut},
                 memStoreAddrOut, memStoreDataOut, addr, data);
      end
      drive(rand_instr(1'b0), 1'b1);
      memStoreAckIn = (i == delay);
      tick();
    end
    memStoreAckIn = 1'b0;
    drive('0, 1'b0);
    n_tests++;
    if ({wbReadyOut, retireValidOut, memStoreReqOut, retireRipOut, retireCountOut} !== {3'b110, t.rip, retired}) begin
      n_fail++;
      $display("FAIL store_retire: got flags=%b rip=%h count=%0d expected flags=110 rip=%h count=%0d",
               {wbReadyOut, retireValidOut, memStoreReqOut}, retireRipOut, retireCountOut, t.rip, retired);
    end
    retired++;
    tick();
    n_tests++;
    if ({wbReadyOut, retireValidOut, memStoreReqOut, retireCountOut} !== {3'b100, retired}) begin
      n_fail++;
      $display("FAIL store_after: got flags=%b count=%0d expected flags=100 count=%0d",
               {wbReadyOut, retireValidOut, memStoreReqOut}, retireCountOut, retired);
    end
  endtask

  task automatic test_back_to_back;
    instr_t q[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      q[i] = rand_instr(1'b0);
      q[i].v1 = 1'b1;
    end
    drive(q[0], 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(q[i+1], 1'b1);
      else       drive('0, 1'b0);
      n_tests++;
      if (regWrEnOut !== p1_fires(q[i]) || (regWrEnOut && {regWrAddrOut, regWrDataOut} !== {q[i].d1, q[i].res}) ||
          regWr2EnOut !== q[i].v2 || (regWr2EnOut && {regWr2AddrOut, regWr2DataOut} !== {q[i].d2, q[i].res2}) ||
          {wbReadyOut, retireValidOut, retireRipOut, retireCountOut} !== {2'b11, q[i].rip, retired}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got en=%b/%b rdy=%b v=%b rip=%h count=%0d expected en=%b/%b rdy=1 v=1 rip=%h count=%0d",
                 i, regWrEnOut, regWr2EnOut, wbReadyOut, retireValidOut, retireRipOut, retireCountOut,
                 p1_fires(q[i]), q[i].v2, q[i].rip, retired);
      end
      retired++;
      tick();
    end
    n_tests++;
    if (retireCountOut !== 64'd5 || regWrEnOut !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: got count=%0d en=%b expected count=5 en=0", retireCountOut, regWrEnOut);
    end
  endtask

  task automatic test_random(input int n);
    instr_t t;
    int delay, gap;
    for (int k = 0; k < n; k++) begin
      t = rand_instr($urandom_range(0, 3) == 0);
      drive(t, 1'b1);
      tick();
      if (!t.mem) begin
        n_tests++;
        if (regWrEnOut !== p1_fires(t) || (regWrEnOut && {regWrAddrOut, regWrDataOut} !== {t.d1, t.res}) ||
            regWr2EnOut !== t.v2 || (regWr2EnOut && {regWr2AddrOut, regWr2DataOut} !== {t.d2, t.res2}) ||
            {wbReadyOut, retireValidOut, memStoreReqOut, retireRipOut, retireCountOut} !== {3'b110, t.rip, retired}) begin
          n_fail++;
          $display("FAIL rnd_reg[%0d]: got en=%b/%b flags=%b rip=%h count=%0d expected en=%b/%b flags=110 rip=%h count=%0d",
                   k, regWrEnOut, regWr2EnOut, {wbReadyOut, retireValidOut, memStoreReqOut}, retireRipOut,
                   retireCountOut, p1_fires(t), t.v2, t.rip, retired);
        end
        retired++;
      end else begin
        delay = $urandom_range(0, 3);
        for (int i = 0; i <= delay; i++) begin
          n_tests++;
          if ({wbReadyOut, retireValidOut, memStoreReqOut, regWrEnOut, regWr2EnOut} !== 5'b00100 ||
              {memStoreAddrOut, memStoreDataOut, retireCountOut} !== {t.addr, t.res, retired}) begin
            n_fail++;
            $display("FAIL rnd_store[%0d.%0d]: got flags=%b addr=%h data=%h count=%0d expected flags=00100 addr=%h data=%h count=%0d",
                     k, i, {wbReadyOut, retireValidOut, memStoreReqOut, regWrEnOut, regWr2EnOut},
                     memStoreAddrOut, memStoreDataOut, retireCountOut, t.addr, t.res, retired);
          end
          drive(rand_instr(1'b1), 1'($urandom));
          memStoreAckIn = (i == delay);
          tick();
        end
        memStoreAckIn = 1'b0;
        n_tests++;
        if ({wbReadyOut, retireValidOut, memStoreReqOut, retireRipOut} !== {3'b110, t.rip}) begin
          n_fail++;
          $display("FAIL rnd_store_retire[%0d]: got flags=%b rip=%h expected flags=110 rip=%h",
                   k, {wbReadyOut, retireValidOut, memStoreReqOut}, retireRipOut, t.rip);
        end
        retired++;
      end
      drive('0, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        n_tests++;
        if ({wbReadyOut, retireValidOut, memStoreReqOut, regWrEnOut, regWr2EnOut, retireCountOut} !== {5'b10000, retired}) begin
          n_fail++;
          $display("FAIL rnd_idle[%0d]: got flags=%b count=%0d expected flags=10000 count=%0d", k,
                   {wbReadyOut, retireValidOut, memStoreReqOut, regWrEnOut, regWr2EnOut}, retireCountOut, retired);
        end
      end
    end
    drive('0, 1'b0);
    tick();
    n_tests++;
    if (retireCountOut !== retired) begin
      n_fail++;
      $display("FAIL rnd_count: got %0d expected %0d", retireCountOut, retired);
    end
  endtask

  task automatic test_kill;
    instr_t t;
    t = rand_instr(1'b1);
    t.kill = 1'b1; t.v1 = 1'b1;
    drive(t, 1'b1);
    tick();
    drive('0, 1'b0);
    n_tests++;
    if ({wbReadyOut, retireValidOut, memStoreReqOut, haltedOut, regWrEnOut, regWr2EnOut, retireRipOut} !== {6'b010100, t.rip}) begin
      n_fail++;
      $display("FAIL kill_entry: got flags=%b rip=%h expected flags=010100 rip=%h",
               {wbReadyOut, retireValidOut, memStoreReqOut, haltedOut, regWrEnOut, regWr2EnOut}, retireRipOut, t.rip);
    end
    retired++;
    for (int i = 0; i < 10; i++) begin
      drive(rand_instr(1'b0), 1'b1);
      tick();
      n_tests++;
      if ({wbReadyOut, retireValidOut, memStoreReqOut, haltedOut, regWrEnOut, regWr2EnOut, retireCountOut} !== {6'b000100, retired}) begin
        n_fail++;
        $display("FAIL kill_hold[%0d]: got flags=%b count=%0d expected flags=000100 count=%0d", i,
                 {wbReadyOut, retireValidOut, memStoreReqOut, haltedOut, regWrEnOut, regWr2EnOut}, retireCountOut, retired);
      end
    end
    do_reset();
    n_tests++;
    if ({wbReadyOut, haltedOut, retireCountOut} !== {2'b10, 64'd0}) begin
      n_fail++;
      $display("FAIL kill_reset: got rdy=%b halted=%b count=%0d expected rdy=1 halted=0 count=0",
               wbReadyOut, haltedOut, retireCountOut);
    end
  endtask

  task automatic test_reset_mid_store;
    instr_t t;
    t = rand_instr(1'b1);
    drive(t, 1'b1);
    tick();
    drive('0, 1'b0);
    tick();
    n_tests++;
    if (memStoreReqOut !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_store_pending: got req=%b expected 1", memStoreReqOut);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    retired = '0;
    n_tests++;
    if ({memStoreReqOut, retireValidOut, wbReadyOut, retireCountOut} !== {3'b001, 64'd0}) begin
      n_fail++;
      $display("FAIL rst_store_drop: got req=%b v=%b rdy=%b count=%0d expected req=0 v=0 rdy=1 count=0",
               memStoreReqOut, retireValidOut, wbReadyOut, retireCountOut);
    end
    memStoreAckIn = 1'b1;
    tick();
    memStoreAckIn = 1'b0;
    tick();
    n_tests++;
    if ({memStoreReqOut, retireValidOut, wbReadyOut, retireCountOut} !== {3'b001, 64'd0}) begin
      n_fail++;
      $display("FAIL rst_late_ack: got req=%b v=%b rdy=%b count=%0d expected req=0 v=0 rdy=1 count=0",
               memStoreReqOut, retireValidOut, wbReadyOut, retireCountOut);
    end
  endtask

  initial begin
    reset = 1'b1;
    memStoreAckIn = 1'b0;
    retired = '0;
    drive('0, 1'b0);
    test_reset();
    test_add();
    test_mul(4'd0, 4'd2);
    test_mul(4'd3, 4'd3);
    test_store(64'h1000, 64'hAB, 3);
    test_store({$urandom, $urandom}, {$urandom, $urandom}, 0);
    test_back_to_back();
    test_random(150);
    test_kill();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage, directly downstream of the execute stage. Captures one executed instruction per handshake into a single-entry pipeline register. Retires it by one of three actions: writing up to two register-file ports, issuing one memory store with a request/acknowledge handshake, or halting the core on a kill (RET/RETF/IRET). Provides the back-pressure that stalls execute while a store is outstanding.

## Interface
Parameters:
- DATA_W, 64, datapath width
- REG_W, 4, register-code width

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- exValidIn  in  1  execute has a successful result this cycle
- wbReadyOut  out  1  stage can accept an instruction this cycle
- aluResultIn  in  64  primary result / store data
- aluResultSpecialIn  in  64  secondary result (MUL/IMUL high half)
- destRegIn  in  4  primary destination register
- destRegValidIn  in  1  primary destination is a register write
- destRegSpecialIn  in  4  secondary destination register (RDX)
- destRegSpecialValidIn  in  1  secondary write required
- isMemoryAccessDestIn  in  1  destination is memory
- memoryAddressDestIn  in  64  store address
- killIn  in  1  instruction terminates execution
- currentRipIn  in  64  RIP of the instruction
- regWrEnOut / regWrAddrOut / regWrDataOut  out  1/4/64  register write port 1
- regWr2EnOut / regWr2AddrOut / regWr2DataOut  out  1/4/64  register write port 2
- memStoreReqOut / memStoreAddrOut / memStoreDataOut  out  1/64/64  store request
- memStoreAckIn  in  1  store accepted by memory
- retireValidOut  out  1  one instruction retired this cycle
- retireRipOut  out  64  RIP of retiring instruction
- retireCountOut  out  64  total retired instructions
- haltedOut  out  1  core halted

## Operation
- Accept condition: exValidIn && wbReadyOut at rising clk; all inputs latched into the pipeline register.
- FSM states: WB_IDLE, WB_REG, WB_STORE, WB_HALTED.
- Next state on accept: killIn -> WB_HALTED; else isMemoryAccessDestIn -> WB_STORE; else WB_REG. kill has priority over store.
- WB_IDLE: wbReadyOut=1, no writes. Stays in WB_IDLE without an accept.
- WB_REG: for exactly one cycle:
  - regWrEnOut = latched destRegValid; address = destReg, data = aluResult.
  - regWr2EnOut = latched destRegSpecialValid; address = destRegSpecial, data = aluResultSpecial.
  - If both enables are set and the addresses are equal, port 1 is suppressed and port 2 wins.
  - retireValidOut=1.
  - wbReadyOut=1. A same-cycle accept goes to the next state per the rules above; otherwise the FSM returns to WB_IDLE.
- WB_STORE:
  - memStoreReqOut=1, with addr = latched address and data = latched aluResult, held stable until memStoreAckIn is sampled high.
  - No register writes; wbReadyOut=0.
  - On ack: retireValidOut=1 in that cycle, then next state WB_IDLE.
  - An ack in the first WB_STORE cycle is legal. An ack outside WB_STORE is ignored.
- WB_HALTED:
  - Entry cycle: retireValidOut=1, no register or memory writes.
  - haltedOut=1 and wbReadyOut=0 from the entry cycle on; the state is left only by reset.
- retireCountOut increments by 1 in every retireValidOut cycle and wraps from 2^64-1 to 0. retireRipOut = latched RIP whenever retireValidOut=1.

## Timing
- Reset values:
  - state WB_IDLE; wbReadyOut=1.
  - All enables, memStoreReqOut, retireValidOut and haltedOut = 0.
  - retireCountOut = 0; address and data outputs = 0.
- Latency: accept at edge N. The register write is visible during cycle N+1 and commits at edge N+2.
- Throughput: one register-writing instruction per cycle, back-to-back.
- Store latency: 1 + k cycles, where k is the number of cycles until ack.
- All outputs are decoded from state and pipeline register only; no combinational path from any input to any output.
- Reset mid-store: memStoreReqOut drops in the cycle after reset is sampled, the pending store is discarded and not retired, and retireCountOut returns to 0.
- Reset while halted: returns to WB_IDLE.

## Structure
- Package wb_pkg holds:
  - wb_state_t enum (WB_IDLE, WB_REG, WB_STORE, WB_HALTED);
  - a wb_entry_t struct of the latched fields;
  - DATA_W and REG_W constants.
- One sub-module, wb_pipe_reg: the single-entry register with load enable and synchronous reset. FSM, write-port decode and the retire counter live in writeback_stage.

## Test plan
- ADD result 0x5, destReg=0, valid; accept at cycle 1 -> regWrEnOut=1, addr=0, data=0x5 in cycle 2 only; retireCountOut=1 in cycle 3.
- MUL: aluResult=0x1, special=0x2, dest=0, special=2, both valid -> both ports fire in the same cycle. Repeat with both addresses=3 -> only port 2 fires.
- Store to 0x1000 of data 0xAB, ack delayed 3 cycles -> req held 4 cycles, addr/data stable, wbReadyOut=0 throughout; retire on the ack cycle, then ready again.
- Five back-to-back register instructions with exValidIn held high -> five consecutive write cycles and retireCountOut=5.
- killIn with isMemoryAccessDestIn=1 -> no store request, haltedOut=1, wbReadyOut stays 0 for 10 cycles; reset -> WB_IDLE, count=0.
- Reset asserted during a waiting store -> req low the next cycle; a late ack is ignored and the count stays 0.
